// File: rtl/sa_pkg.sv
// Shared package for the systolic-array side blocks.
// Holds the default operand geometry and the loader state encoding so the
// loader and the array-side consumers agree on both.
package sa_pkg;

  // Default signed element width and array dimension (lanes per operand).
  localparam int unsigned SA_DIN_WIDTH = 8;
  localparam int unsigned SA_N         = 4;
  // One beat carries N A-lanes (low half) and N B-lanes (high half).
  localparam int unsigned SA_BUS_WIDTH = 2 * SA_DIN_WIDTH * SA_N;

  typedef enum logic {
    StLoad = 1'b0,
    StEmit = 1'b1
  } sa_state_e;

endpackage

// File: rtl/operand_skew_loader_if.sv
// Bus bundle for operand_skew_loader.
// Upstream tile beats:  s_data, s_valid, s_ready
// Downstream FIFO side: din, wr_fifo, in_fifo_full
// Status:               busy, tile_done
// Modports: slave = loader view, master = environment (source + FIFO) view.
interface operand_skew_loader_if
  import sa_pkg::*;
#(
  parameter int unsigned DIN_WIDTH = SA_DIN_WIDTH,
  parameter int unsigned N         = SA_N,
  parameter int unsigned BUS_WIDTH = 2 * DIN_WIDTH * N
) ();

  logic [BUS_WIDTH-1:0] s_data;
  logic                 s_valid;
  logic                 s_ready;
  logic [BUS_WIDTH-1:0] din;
  logic                 wr_fifo;
  logic                 in_fifo_full;
  logic                 busy;
  logic                 tile_done;

  modport slave (
    input  s_data, s_valid, in_fifo_full,
    output s_ready, din, wr_fifo, busy, tile_done
  );

  modport master (
    output s_data, s_valid, in_fifo_full,
    input  s_ready, din, wr_fifo, busy, tile_done
  );

endinterface

// File: rtl/operand_skew_loader.sv
// Operand skew loader.
// Collects N tile beats (A column k in the low half, B row k in the high half),
// then emits 2N-1 diagonally skewed beats to the array input FIFO so lane i of
// A (and lane j of B) is delayed by i (j) beats. Out-of-window lanes are zero.
// Ports:
//   sys_clk - rising-edge clock
//   rst_n   - synchronous active-low reset
//   bus     - operand_skew_loader_if.slave (tile input, FIFO output, status)
module operand_skew_loader
  import sa_pkg::*;
#(
  parameter int unsigned DIN_WIDTH = SA_DIN_WIDTH,
  parameter int unsigned N         = SA_N,
  parameter int unsigned BUS_WIDTH = 2 * DIN_WIDTH * N
) (
  input logic                  sys_clk,
  input logic                  rst_n,
  operand_skew_loader_if.slave bus
);

  localparam int unsigned LaneW = N * DIN_WIDTH;
  localparam int unsigned CntW  = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned EmitW = $clog2(2 * N);

  localparam logic [CntW-1:0]  LastLoad = CntW'(N - 1);
  localparam logic [EmitW-1:0] LastEmit = EmitW'(2 * N - 2);

  sa_state_e        state_q, state_d;
  logic [CntW-1:0]  load_cnt_q, load_cnt_d;
  logic [EmitW-1:0] emit_cnt_q, emit_cnt_d;
  logic             tile_done_q, tile_done_d;
  logic             buf_we;
  logic             emitting;
  logic             wr;

  logic [2*LaneW-1:0] buf_q [N];
  logic [2*LaneW-1:0] din_lanes;

  assign emitting      = (state_q == StEmit);
  assign wr            = emitting && !bus.in_fifo_full;
  assign bus.s_ready   = !emitting;
  assign bus.wr_fifo   = wr;
  assign bus.busy      = emitting;
  assign bus.tile_done = tile_done_q;
  assign bus.din       = BUS_WIDTH'(din_lanes);

  always_comb begin
    state_d     = state_q;
    load_cnt_d  = load_cnt_q;
    emit_cnt_d  = emit_cnt_q;
    tile_done_d = 1'b0;
    buf_we      = 1'b0;
    unique case (state_q)
      StLoad: begin
        if (bus.s_valid) begin
          buf_we = 1'b1;
          if (load_cnt_q == LastLoad) begin
            load_cnt_d = '0;
            emit_cnt_d = '0;
            state_d    = StEmit;
          end else begin
            load_cnt_d = load_cnt_q + CntW'(1);
          end
        end
      end
      StEmit: begin
        // Counter only moves on an actual write, so a full FIFO freezes din.
        if (wr) begin
          if (emit_cnt_q == LastEmit) begin
            emit_cnt_d  = '0;
            state_d     = StLoad;
            tile_done_d = 1'b1;
          end else begin
            emit_cnt_d = emit_cnt_q + EmitW'(1);
          end
        end
      end
      default: state_d = StLoad;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state_q     <= StLoad;
      load_cnt_q  <= '0;
      emit_cnt_q  <= '0;
      tile_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      load_cnt_q  <= load_cnt_d;
      emit_cnt_q  <= emit_cnt_d;
      tile_done_q <= tile_done_d;
    end
  end

  // Tile storage is not reset; a fresh tile always overwrites every slot
  // before it can be emitted.
  always_ff @(posedge sys_clk) begin
    if (buf_we) begin
      buf_q[load_cnt_q] <= bus.s_data[2*LaneW-1:0];
    end
  end

  // Lane g at step t reads beat t-g: A[g][t-g] from the low half and
  // B[t-g][g] from the high half. Outside 0 <= t-g < N the lane is masked.
  for (genvar g = 0; g < N; g++) begin : g_lane
    logic [EmitW-1:0] k;
    logic             hit;

    always_comb begin
      k   = emit_cnt_q - EmitW'(g);
      hit = emitting && (emit_cnt_q >= EmitW'(g)) && (k < EmitW'(N));
    end

    assign din_lanes[g*DIN_WIDTH +: DIN_WIDTH] =
        hit ? buf_q[k[CntW-1:0]][g*DIN_WIDTH +: DIN_WIDTH] : '0;
    assign din_lanes[LaneW + g*DIN_WIDTH +: DIN_WIDTH] =
        hit ? buf_q[k[CntW-1:0]][LaneW + g*DIN_WIDTH +: DIN_WIDTH] : '0;
  end

endmodule

// File: tb/tb_operand_skew_loader.sv
// Self-checking bench for operand_skew_loader (N=4, DIN_WIDTH=8).
// A matrix-level reference model predicts every cycle's outputs; a vector
// table pins the hand-derived skew beats of the reference tile.
module tb_operand_skew_loader;

  localparam int DW = 8;
  localparam int NL = 4;
  localparam int BW = 2 * DW * NL;
  localparam int HW = DW * NL;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  operand_skew_loader_if #(.DIN_WIDTH(DW), .N(NL), .BUS_WIDTH(BW)) bus ();

  operand_skew_loader #(
    .DIN_WIDTH(DW),
    .N        (NL),
    .BUS_WIDTH(BW)
  ) dut (
    .sys_clk(clk),
    .rst_n  (rst_n),
    .bus    (bus.slave)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference model: matrices of the tile being loaded and the queue of
  // beats still owed to the FIFO.
  logic [DW-1:0] ma [NL][NL];
  logic [DW-1:0] mb [NL][NL];
  logic [BW-1:0] exp_q [$];
  logic [BW-1:0] wr_log [$];
  int            done_at [$];
  int            acc_cnt   = 0;
  bit            done_pend = 1'b0;

  typedef struct {
    int          beat;
    logic [HW-1:0] a;
    logic [HW-1:0] b;
  } vec_t;
  vec_t tbl [4];

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chkv(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Skewed beat t of the loaded tile, straight from the matrix definition.
  function automatic logic [BW-1:0] beat_of(input int t);
    logic [BW-1:0] r;
    r = '0;
    for (int i = 0; i < NL; i++) begin
      if (t - i >= 0 && t - i < NL) begin
        r[i*DW +: DW]        = ma[i][t-i];
        r[(NL+i)*DW +: DW]   = mb[t-i][i];
      end
    end
    return r;
  endfunction

  // Reference tile: A[i][k]=0x10*i+k, B[k][j]=0x40+0x10*k+j.
  function automatic logic [BW-1:0] ref_beat(input int k);
    logic [BW-1:0] r;
    for (int i = 0; i < NL; i++) begin
      r[i*DW +: DW]      = 8'(16 * i + k);
      r[(NL+i)*DW +: DW] = 8'(64 + 16 * k + i);
    end
    return r;
  endfunction

  // One clock: drive, check against the model, advance the model, clock.
  task automatic run_cycle(input bit v, input logic [BW-1:0] d, input bit full, input bit rstn);
    bit em;
    bus.s_valid      = v;
    bus.s_data       = d;
    bus.in_fifo_full = full;
    rst_n            = rstn;
    #1;
    em = (exp_q.size() != 0);
    chk1("s_ready", bus.s_ready, !em);
    chk1("busy", bus.busy, em);
    chk1("wr_fifo", bus.wr_fifo, em && !full);
    chk1("tile_done", bus.tile_done, done_pend);
    chkv("din", bus.din, em ? exp_q[0] : '0);
    if (bus.wr_fifo) wr_log.push_back(bus.din);
    if (bus.tile_done) done_at.push_back(cyc);
    done_pend = 1'b0;
    if (!rstn) begin
      exp_q.delete();
      acc_cnt = 0;
    end else if (em) begin
      if (!full) begin
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) done_pend = 1'b1;
      end
    end else if (v) begin
      for (int i = 0; i < NL; i++) begin
        ma[i][acc_cnt] = d[i*DW +: DW];
        mb[acc_cnt][i] = d[(NL+i)*DW +: DW];
      end
      acc_cnt++;
      if (acc_cnt == NL) begin
        for (int t = 0; t < 2 * NL - 1; t++) exp_q.push_back(beat_of(t));
        acc_cnt = 0;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic load_ref();
    for (int k = 0; k < NL; k++) run_cycle(1'b1, ref_beat(k), 1'b0, 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) run_cycle(1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic check_table(input string tag);
    logic [BW-1:0] got;
    chki({tag, "_wr_count"}, wr_log.size(), 2 * NL - 1);
    for (int i = 0; i < 4; i++) begin
      got = (tbl[i].beat < wr_log.size()) ? wr_log[tbl[i].beat] : 'x;
      chkv($sformatf("%s_beat%0d", tag, tbl[i].beat), got, {tbl[i].b, tbl[i].a});
    end
  endtask

  // Presents beats in order, advancing only when the model says accepted.
  task automatic stream(input logic [BW-1:0] beats [$], input int gap_pct, input int full_pct);
    int guard;
    bit v;
    bit acc;
    logic [BW-1:0] d;
    guard = 0;
    while ((beats.size() != 0 || exp_q.size() != 0 || done_pend) && guard < 3000) begin
      v   = (beats.size() != 0) && ($urandom_range(99) >= gap_pct);
      d   = v ? beats[0] : BW'({$urandom(), $urandom()});
      acc = v && (exp_q.size() == 0);
      run_cycle(v, d, $urandom_range(99) < full_pct, 1'b1);
      if (acc) void'(beats.pop_front());
      guard++;
    end
    chk1("stream_done", guard < 3000, 1'b1);
  endtask

  initial begin
    logic [BW-1:0] q [$];
    logic [BW-1:0] held;
    int            n;
    bit            pat [10];

    tbl[0] = '{0, 32'h0000_0000, 32'h0000_0040};
    tbl[1] = '{1, 32'h0000_1001, 32'h0000_4150};
    tbl[2] = '{3, 32'h3021_1203, 32'h4352_6170};
    tbl[3] = '{6, 32'h3300_0000, 32'h7300_0000};

    bus.s_valid      = 1'b0;
    bus.s_data       = '0;
    bus.in_fifo_full = 1'b0;
    rst_n            = 1'b0;
    @(posedge clk);
    #1;
    run_cycle(1'b0, '0, 1'b0, 1'b0);
    idle(1);

    // Basic skew of the reference tile.
    wr_log.delete();
    load_ref();
    idle(2 * NL);
    check_table("basic");

    // Backpressure at emit_cnt=2 for three cycles.
    wr_log.delete();
    load_ref();
    idle(2);
    held = bus.din;
    repeat (3) begin
      run_cycle(1'b0, '0, 1'b1, 1'b1);
      chkv("stall_din", bus.din, held);
    end
    idle(2 * NL - 3);
    check_table("stall");

    // s_valid held high with junk through EMIT, next tile starts at tile_done.
    wr_log.delete();
    load_ref();
    repeat (2 * NL - 1) run_cycle(1'b1, BW'({$urandom(), $urandom()}), 1'b0, 1'b1);
    check_table("junk");
    wr_log.delete();
    load_ref();
    idle(2 * NL);
    check_table("followon");

    // Sparse s_valid during LOAD.
    pat = '{1, 0, 0, 1, 0, 1, 0, 0, 0, 1};
    n = 0;
    for (int i = 0; i < 10; i++) begin
      run_cycle(pat[i], pat[i] ? ref_beat(n) : '0, 1'b0, 1'b1);
      if (pat[i]) n++;
    end
    idle(2 * NL);

    // Reset mid-EMIT at emit_cnt=3, then mid-LOAD.
    load_ref();
    idle(3);
    run_cycle(1'b0, '0, 1'b0, 1'b0);
    n = wr_log.size();
    idle(3);
    chki("no_wr_after_reset", wr_log.size(), n);
    run_cycle(1'b1, ref_beat(0), 1'b0, 1'b1);
    run_cycle(1'b1, ref_beat(1), 1'b0, 1'b1);
    run_cycle(1'b0, '0, 1'b0, 1'b0);
    run_cycle(1'b1, ref_beat(2), 1'b0, 1'b1);
    run_cycle(1'b1, ref_beat(3), 1'b0, 1'b1);
    idle(2);
    chki("no_wr_partial_tile", wr_log.size(), n);
    q.delete();
    for (int k = 0; k < NL; k++) q.push_back(ref_beat(k));
    stream(q, 30, 0);

    // Back-to-back tiles of negative values; period must be N + 2N-1.
    done_at.delete();
    q.delete();
    for (int k = 0; k < 2 * NL; k++) begin
      q.push_back(k[0] ? {8{8'hFF}} : {4{8'h80, 8'hFF}} ^ BW'(k));
    end
    stream(q, 0, 0);
    chki("tile_count", done_at.size(), 2);
    if (done_at.size() >= 2) chki("tile_period", done_at[1] - done_at[0], 3 * NL - 1);

    // Random traffic with backpressure and occasional reset.
    q.delete();
    for (int k = 0; k < 8 * NL; k++) q.push_back(BW'({$urandom(), $urandom()}));
    stream(q, 30, 25);
    for (int i = 0; i < 400; i++) begin
      run_cycle($urandom_range(99) < 70, BW'({$urandom(), $urandom()}),
                $urandom_range(99) < 20, $urandom_range(99) >= 2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/operand_skew_loader.md
OPERAND_SKEW_LOADER -- requirements
Module: operand_skew_loader

Interface
REQ-001 SHALL have parameter DIN_WIDTH, default 8, signed operand element width.
REQ-002 SHALL have parameter N, default 4, array dimension (lanes per operand).
REQ-003 SHALL have parameter BUS_WIDTH, default 2*DIN_WIDTH*N, packed beat width.
REQ-004 SHALL have port sys_clk  in  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port s_data  in  BUS_WIDTH  tile beat k: A column k in lanes [N*DIN_WIDTH-1:0] (lane i = A[i][k]), B row k in upper half (lane j = B[k][j]).
REQ-007 SHALL have port s_valid  in  1  s_data valid.
REQ-008 SHALL have port s_ready  out  1  loader accepts s_data this cycle.
REQ-009 SHALL have port din  out  BUS_WIDTH  skewed beat to the array input FIFO, same A-low/B-high packing.
REQ-010 SHALL have port wr_fifo  out  1  din write strobe.
REQ-011 SHALL have port in_fifo_full  in  1  downstream input FIFO full.
REQ-012 SHALL have port busy  out  1  high in EMIT.
REQ-013 SHALL have port tile_done  out  1  one-cycle pulse after the last skewed beat of a tile is written.

Function
REQ-014 SHALL implement a two-state FSM: LOAD (s_ready=1, wr_fifo=0) and EMIT (s_ready=0).
REQ-015 SHALL accept a beat on s_valid && s_ready, storing it in buffer slot load_cnt, then increment load_cnt (0..N-1).
REQ-016 SHALL transition LOAD->EMIT on the cycle the Nth beat is accepted, with load_cnt returning to 0 and emit_cnt cleared to 0.
REQ-017 SHALL drive, in EMIT at emit_cnt=t (0..2N-2), A lane i = stored A[i][t-i] and B lane j = stored B[t-j][j] when 0<=t-i<N (resp. t-j), else exactly 0.
REQ-018 SHALL generate din combinationally from state, emit_cnt and the buffer; din SHALL be all-zero outside EMIT.
REQ-019 SHALL assert wr_fifo = (state==EMIT) && !in_fifo_full, combinationally.
REQ-020 SHALL advance emit_cnt only on cycles with wr_fifo=1; while in_fifo_full=1, emit_cnt and din SHALL hold.
REQ-021 SHALL transition EMIT->LOAD on the cycle the beat with emit_cnt=2N-2 is written, and SHALL pulse tile_done in the following cycle.
REQ-022 SHALL ignore s_valid in EMIT; the buffer SHALL NOT change in EMIT.
REQ-023 SHALL achieve minimum tile throughput of N load cycles plus 2N-1 emit cycles, with the first wr_fifo the cycle after the Nth accept.
REQ-024 SHALL pass elements unmodified (no arithmetic); zero padding SHALL come from lane masking, not buffer contents.

Reset
REQ-025 SHALL, when rst_n=0 at a sys_clk edge, set state=LOAD, load_cnt=0, emit_cnt=0, tile_done=0.
REQ-026 SHALL output s_ready=1, wr_fifo=0, busy=0 and din=0 after reset; buffer contents need not be reset.
REQ-027 SHALL, on reset mid-LOAD or mid-EMIT, discard the partial tile, with no further wr_fifo until a complete new tile is loaded.

Structure
REQ-028 SHALL take DIN_WIDTH, N, BUS_WIDTH defaults and the LOAD/EMIT state enum from shared package sa_pkg, reused by the array-side blocks.
REQ-029 SHALL be a single flat module; per-lane skew selection SHALL be a generate loop, not a sub-module.

Verification
REQ-030 SHALL cover basic skew (N=4, DIN_WIDTH=8): A[i][k]=0x10*i+k, B[k][j]=0x40+0x10*k+j, with the following required beats:
- beat0: A lanes {0x00,0,0,0}, B lanes {0x40,0,0,0}
- beat3: A lanes {0x03,0x12,0x21,0x30}, B lanes {0x70,0x61,0x52,0x43}
- beat6: A lanes {0,0,0,0x33}, B lanes {0,0,0,0x73}
- exactly 7 wr_fifo pulses, then tile_done.
REQ-031 SHALL cover backpressure: in_fifo_full=1 for 3 cycles at emit_cnt=2 -> wr_fifo=0 and din stable for those 3 cycles, then the identical 7-beat sequence.
REQ-032 SHALL cover s_valid held high through EMIT with different data -> s_ready=0, emitted beats unchanged, and the next tile loads only after tile_done.
REQ-033 SHALL cover sparse s_valid gaps during LOAD -> EMIT entered exactly the cycle after the 4th accept.
REQ-034 SHALL cover rst_n=0 for 1 cycle at emit_cnt=3 -> wr_fifo=0 next cycle, busy=0, s_ready=1, and no write until 4 new beats are accepted.
REQ-035 SHALL cover back-to-back tiles with negative values (0x80, 0xFF) -> values passed bit-exact, with 4+7 cycle tile period when not stalled.
